instr_realign_ctrl: RTL and testbench
=====================================

Name: instr_realign_ctrl

Overview:
- Sits between the 32-bit instruction fetch port and the compressed decoder.
- Turns a stream of word-aligned 32-bit fetch words into a stream of whole instructions, either 16-bit compressed or 32-bit, including 32-bit instructions that straddle two fetch words.
- Tracks the PC of each instruction and handles redirects to halfword-aligned targets.
- Owns all fetch backpressure, so the decoder sees exactly one complete instruction per valid cycle.

Parameters:
- BOOT_ADDR, 32'h0000_0000: PC after reset. Bit 1 is honoured; bit 0 is ignored.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- fetch_word_i  in  32  fetch word; the halfword at the lower address is in [15:0]
- fetch_valid_i  in  1  fetch_word_i is valid
- fetch_ready_o  out  1  fetch word consumed this cycle
- flush_i  in  1  redirect request; takes priority over everything else
- flush_pc_i  in  32  redirect target
- instr_o  out  32  raw instruction to the decoder; upper 16 bits are 0 when compressed
- instr_pc_o  out  32  PC of instr_o
- instr_compressed_o  out  1  instr_o is 16-bit
- instr_valid_o  out  1  output register holds an instruction
- instr_ready_i  in  1  decoder accepts instr_o
- perf_cmp_cnt_o  out  32  compressed-instruction count (optional feature)
- perf_split_cnt_o  out  32  word-straddling-instruction count (optional feature)

Behaviour:
- State machine, 3 states:
  - ALIGNED: no leftover halfword.
  - HALF: hold_q[15:0] holds the upper halfword of the previous word.
  - SKIP: next word's lower halfword is discarded.
- Reset values:
  - All outputs 0.
  - State = SKIP if BOOT_ADDR[1] is set, otherwise ALIGNED.
  - pc_q = {BOOT_ADDR[31:1], 1'b0}; hold_q = 0.
- adv = !instr_valid_o || instr_ready_i. The output register loads only when adv is high and an instruction is produced.
- Latency: 1 cycle from producing an instruction to instr_valid_o. Full throughput is 1 instruction per cycle.
- ALIGNED, fetch_valid_i && adv:
  - If word[1:0] != 2'b11: emit {16'h0, word[15:0]}, compressed = 1. hold_q <= word[31:16]. Go to HALF. pc_q += 2.
  - Otherwise: emit the whole word. Stay in ALIGNED. pc_q += 4.
  - fetch_ready_o = 1 in both cases.
- HALF, hold_q[1:0] != 2'b11, adv:
  - Emit compressed hold_q with no fetch needed; fetch_ready_o = 0.
  - Go to ALIGNED; pc_q += 2.
- HALF, hold_q[1:0] == 2'b11, fetch_valid_i && adv:
  - Emit {word[15:0], hold_q}; fetch_ready_o = 1.
  - hold_q <= word[31:16]; stay in HALF; pc_q += 4.
  - perf_split_cnt increments.
- SKIP, fetch_valid_i:
  - fetch_ready_o = 1 and no instruction is emitted; the output register is left untouched.
  - hold_q <= word[31:16]; go to HALF.
- No valid instruction can be formed (word not valid, or adv low): fetch_ready_o = 0, the output register holds, and the state does not change.
- instr_pc_o is the pc_q value loaded with the instruction.
- flush_i:
  - Clears instr_valid_o in the same cycle's update.
  - pc_q <= {flush_pc_i[31:1], 1'b0}.
  - State becomes SKIP if flush_pc_i[1] is set, otherwise ALIGNED.
  - fetch_ready_o = 1 so any presented word is dropped; hold_q is discarded.
  - A simultaneous decoder accept is ignored.
- Back-to-back flushes: the last one wins.
- Reset asserted mid-stream returns everything to reset values asynchronously.
- pc_q wraps modulo 2^32.

Optional Feature:
- Macro: REALIGN_PERF_CNT_EN.
- Defined: perf_cmp_cnt_o and perf_split_cnt_o are 32-bit wrapping counters.
  - Each counter increments when the matching instruction is accepted (instr_valid_o && instr_ready_i).
  - Counters reset to 0 on rst_i and do not clear on flush.
- Not defined: both ports are tied to 32'h0 and no counter flops are built.

Test Plan:
- Boot at 0, words 32'h0013_0513 then 32'h4501_4505 with instr_ready_i held 1 → outputs:
  - 00130513 at PC 0, 32-bit.
  - 4505 at PC 4, compressed.
  - 4501 at PC 6, compressed.
  - fetch_ready_o low on the cycle 4501 is emitted.
- Straddle: words 32'h0513_4505 then 32'hxxxx_0013 → outputs 4505 at PC 0, then 00130513 at PC 2; the split counter equals 1 when the feature is enabled.
- Backpressure: hold instr_ready_i at 0 for 3 cycles mid-stream → instr_o, instr_pc_o and state are stable, fetch_ready_o = 0, and no instruction is lost or duplicated.
- Flush to 32'h0000_0102 with word 32'h4505_ABCD next → ABCD is skipped; output is 4505 at PC 0x102, compressed.
- Flush while in HALF with instr_valid_o = 1 → instr_valid_o = 0 next cycle and the old hold_q never appears at the output.
- Assert rst_i mid-stream with BOOT_ADDR = 32'h0000_0082 → all outputs go to 0 immediately; the first emitted instruction is the upper halfword of the first word, at PC 0x82.

Source files
------------

// File: rtl/instr_realign_ctrl.sv
// Realigns word-aligned 32-bit fetch words into whole 16/32-bit instructions with PC tracking.
// Optional performance counters are built when REALIGN_PERF_CNT_EN is defined.
module instr_realign_ctrl #(
    parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] fetch_word_i,
    input  logic        fetch_valid_i,
    output logic        fetch_ready_o,
    input  logic        flush_i,
    input  logic [31:0] flush_pc_i,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic        instr_compressed_o,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] perf_cmp_cnt_o,
    output logic [31:0] perf_split_cnt_o
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned HW   = 16;

    typedef enum logic [1:0] {
        ST_ALIGNED = 2'd0,
        ST_HALF    = 2'd1,
        ST_SKIP    = 2'd2
    } state_e;

    localparam state_e          RST_STATE = BOOT_ADDR[1] ? ST_SKIP : ST_ALIGNED;
    localparam logic [XLEN-1:0] RST_PC    = {BOOT_ADDR[XLEN-1:1], 1'b0};

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] instr_pc_q, instr_pc_d;
    logic            instr_cmp_q, instr_cmp_d;
    logic            instr_valid_q, instr_valid_d;

    logic            adv;
    logic            fetch_ready_c;
    logic            emit;
    logic [XLEN-1:0] emit_instr;
    logic            emit_cmp;

    // Only the halfword-aligned part of a redirect target is meaningful.
    logic unused_flush_lsb;
    assign unused_flush_lsb = flush_pc_i[0];

    assign adv = !instr_valid_q || instr_ready_i;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        hold_d        = hold_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_cmp_d   = instr_cmp_q;
        instr_valid_d = instr_valid_q;
        fetch_ready_c = 1'b0;
        emit          = 1'b0;
        emit_instr    = '0;
        emit_cmp      = 1'b0;

        if (flush_i) begin
            instr_valid_d = 1'b0;
            pc_d          = {flush_pc_i[XLEN-1:1], 1'b0};
            state_d       = flush_pc_i[1] ? ST_SKIP : ST_ALIGNED;
            hold_d        = '0;
            fetch_ready_c = 1'b1;
        end else begin
            // Accepted (or empty) output slot drains unless refilled below.
            if (adv) begin
                instr_valid_d = 1'b0;
            end
            case (state_q)
                ST_ALIGNED: begin
                    if (fetch_valid_i && adv) begin
                        fetch_ready_c = 1'b1;
                        emit          = 1'b1;
                        if (fetch_word_i[1:0] != 2'b11) begin
                            emit_instr = {16'h0000, fetch_word_i[HW-1:0]};
                            emit_cmp   = 1'b1;
                            hold_d     = fetch_word_i[XLEN-1:HW];
                            state_d    = ST_HALF;
                            pc_d       = pc_q + 32'd2;
                        end else begin
                            emit_instr = fetch_word_i;
                            pc_d       = pc_q + 32'd4;
                        end
                    end
                end
                ST_HALF: begin
                    if (hold_q[1:0] != 2'b11) begin
                        if (adv) begin
                            emit       = 1'b1;
                            emit_instr = {16'h0000, hold_q};
                            emit_cmp   = 1'b1;
                            state_d    = ST_ALIGNED;
                            pc_d       = pc_q + 32'd2;
                        end
                    end else if (fetch_valid_i && adv) begin
                        fetch_ready_c = 1'b1;
                        emit          = 1'b1;
                        emit_instr    = {fetch_word_i[HW-1:0], hold_q};
                        hold_d        = fetch_word_i[XLEN-1:HW];
                        pc_d          = pc_q + 32'd4;
                    end
                end
                ST_SKIP: begin
                    if (fetch_valid_i) begin
                        fetch_ready_c = 1'b1;
                        hold_d        = fetch_word_i[XLEN-1:HW];
                        state_d       = ST_HALF;
                    end
                end
                default: begin
                    state_d = ST_ALIGNED;
                end
            endcase

            if (emit) begin
                instr_d       = emit_instr;
                instr_pc_d    = pc_q;
                instr_cmp_d   = emit_cmp;
                instr_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= RST_STATE;
            pc_q          <= RST_PC;
            hold_q        <= '0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_cmp_q   <= 1'b0;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            hold_q        <= hold_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_cmp_q   <= instr_cmp_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    // Nothing is consumed while the block is held in reset.
    assign fetch_ready_o      = fetch_ready_c && !rst_i;
    assign instr_o            = instr_q;
    assign instr_pc_o         = instr_pc_q;
    assign instr_compressed_o = instr_cmp_q;
    assign instr_valid_o      = instr_valid_q;

`ifdef REALIGN_PERF_CNT_EN
    logic [XLEN-1:0] perf_cmp_q, perf_cmp_d;
    logic [XLEN-1:0] perf_split_q, perf_split_d;

    // A 32-bit instruction at an odd-halfword PC is exactly one that straddled two words.
    always_comb begin
        perf_cmp_d   = perf_cmp_q;
        perf_split_d = perf_split_q;
        if (instr_valid_q && instr_ready_i && !flush_i) begin
            if (instr_cmp_q) begin
                perf_cmp_d = perf_cmp_q + 32'd1;
            end else if (instr_pc_q[1]) begin
                perf_split_d = perf_split_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            perf_cmp_q   <= '0;
            perf_split_q <= '0;
        end else begin
            perf_cmp_q   <= perf_cmp_d;
            perf_split_q <= perf_split_d;
        end
    end

    assign perf_cmp_cnt_o   = perf_cmp_q;
    assign perf_split_cnt_o = perf_split_q;
`else
    assign perf_cmp_cnt_o   = 32'h0;
    assign perf_split_cnt_o = 32'h0;
`endif

endmodule

// File: tb/tb_instr_realign_ctrl.sv
// Bench for instr_realign_ctrl: halfword-memory reference model parsed from the PC, plus directed scenarios.
module tb_instr_realign_ctrl;

    localparam logic [31:0] BOOT = 32'h0000_0082;

    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic [31:0] fetch_word_i = '0;
    logic        fetch_valid_i = 1'b0;
    logic        fetch_ready_o;
    logic        flush_i = 1'b0;
    logic [31:0] flush_pc_i = '0;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_compressed_o;
    logic        instr_valid_o;
    logic        instr_ready_i = 1'b0;
    logic [31:0] perf_cmp_cnt_o;
    logic [31:0] perf_split_cnt_o;

    instr_realign_ctrl #(.BOOT_ADDR(BOOT)) dut (
        .clk_i              (clk),
        .rst_i              (rst_i),
        .fetch_word_i       (fetch_word_i),
        .fetch_valid_i      (fetch_valid_i),
        .fetch_ready_o      (fetch_ready_o),
        .flush_i            (flush_i),
        .flush_pc_i         (flush_pc_i),
        .instr_o            (instr_o),
        .instr_pc_o         (instr_pc_o),
        .instr_compressed_o (instr_compressed_o),
        .instr_valid_o      (instr_valid_o),
        .instr_ready_i      (instr_ready_i),
        .perf_cmp_cnt_o     (perf_cmp_cnt_o),
        .perf_split_cnt_o   (perf_split_cnt_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_acc  = 0;

    // Program memory seen as halfwords; mpc is the PC of the next instruction to be accepted.
    logic [15:0] mem [0:255];
    logic [31:0] mpc = BOOT;
    logic [31:0] faddr = 32'h80;
    logic [31:0] ecmp = '0;
    logic [31:0] esplit = '0;
    logic        last_fr = 1'b0;
    logic [31:0] last_acc_instr = '0;
    logic [31:0] last_acc_pc = '0;

    function automatic logic [15:0] hw_at(input logic [31:0] a);
        return mem[a[8:1]];
    endfunction

    // One clock: drive at negedge, sample just before posedge, update model at next negedge.
    task automatic tick(input logic fv, input logic rdy, input logic fl, input logic [31:0] fpc);
        logic        acc;
        logic [31:0] si, sp, ei;
        logic        sc, ec;
        logic [15:0] lo;
        fetch_valid_i = fv;
        instr_ready_i = rdy;
        flush_i       = fl;
        flush_pc_i    = fpc;
        fetch_word_i  = {hw_at(faddr + 32'd2), hw_at(faddr)};
        #4;
        last_fr = fetch_ready_o;
        acc     = instr_valid_o && rdy;
        si      = instr_o;
        sp      = instr_pc_o;
        sc      = instr_compressed_o;
        @(negedge clk);
        if (!rst_i) begin
            if (fl) begin
                mpc   = {fpc[31:1], 1'b0};
                faddr = {fpc[31:2], 2'b00};
            end else begin
                if (acc) begin
                    lo = hw_at(mpc);
                    if (lo[1:0] == 2'b11) begin
                        ei = {hw_at(mpc + 32'd2), lo};
                        ec = 1'b0;
                    end else begin
                        ei = {16'h0000, lo};
                        ec = 1'b1;
                    end
                    checks++;
                    if (si !== ei || sp !== mpc || sc !== ec) begin
                        errors++;
                        $display("FAIL stream: got instr=%h pc=%h cmp=%b, expected instr=%h pc=%h cmp=%b",
                                 si, sp, sc, ei, mpc, ec);
                    end
                    if (ec) ecmp = ecmp + 32'd1;
                    else if (mpc[1]) esplit = esplit + 32'd1;
                    mpc = mpc + (ec ? 32'd2 : 32'd4);
                    n_acc++;
                    last_acc_instr = si;
                    last_acc_pc    = sp;
                end
                if (fv && last_fr) faddr = faddr + 32'd4;
            end
        end
    endtask

    task automatic run_until(input int target, input int budget, input string name);
        int k = 0;
        while (n_acc < target && k < budget) begin
            tick(1'b1, 1'b1, 1'b0, 32'h0);
            k++;
        end
        checks++;
        if (n_acc < target) begin
            errors++;
            $display("FAIL %s timeout: accepted %0d, required %0d", name, n_acc, target);
        end
    endtask

    task automatic check_perf(input string name);
        logic [31:0] exp_c, exp_s;
`ifdef REALIGN_PERF_CNT_EN
        exp_c = ecmp;
        exp_s = esplit;
`else
        exp_c = 32'h0;
        exp_s = 32'h0;
`endif
        checks++;
        if (perf_cmp_cnt_o !== exp_c || perf_split_cnt_o !== exp_s) begin
            errors++;
            $display("FAIL %s perf: got cmp=%0d split=%0d, expected cmp=%0d split=%0d",
                     name, perf_cmp_cnt_o, perf_split_cnt_o, exp_c, exp_s);
        end
    endtask

    // Asynchronous reset from the middle of a cycle, then first instruction after BOOT_ADDR.
    task automatic test_reset;
        mem[8'h40] = 16'hABCF;
        mem[8'h41] = 16'h4505;
        fetch_valid_i = 1'b1;
        instr_ready_i = 1'b1;
        flush_i       = 1'b0;
        #2 rst_i = 1'b1;
        #1;
        checks++;
        if (instr_valid_o !== 1'b0 || instr_o !== 32'h0 || instr_pc_o !== 32'h0 ||
            instr_compressed_o !== 1'b0 || fetch_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b i=%h pc=%h c=%b fr=%b, expected all 0",
                     instr_valid_o, instr_o, instr_pc_o, instr_compressed_o, fetch_ready_o);
        end
        checks++;
        if (perf_cmp_cnt_o !== 32'h0 || perf_split_cnt_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_perf: got %h %h, expected 0 0", perf_cmp_cnt_o, perf_split_cnt_o);
        end
        @(negedge clk);
        @(negedge clk);
        rst_i  = 1'b0;
        mpc    = {BOOT[31:1], 1'b0};
        faddr  = {BOOT[31:2], 2'b00};
        ecmp   = '0;
        esplit = '0;
        run_until(n_acc + 1, 10, "reset_first");
        checks++;
        if (last_acc_pc !== 32'h82 || last_acc_instr !== 32'h0000_4505) begin
            errors++;
            $display("FAIL reset_first_instr: got %h at %h, expected 00004505 at 00000082",
                     last_acc_instr, last_acc_pc);
        end
        check_perf("reset");
    endtask

    task automatic test_aligned_stream;
        logic found = 1'b0;
        mem[0] = 16'h0513; mem[1] = 16'h0013; mem[2] = 16'h4505; mem[3] = 16'h4501;
        tick(1'b0, 1'b1, 1'b1, 32'h0);
        for (int i = 0; i < 6; i++) begin
            tick(1'b1, 1'b1, 1'b0, 32'h0);
            if (!found && instr_valid_o && instr_o === 32'h0000_4501 && instr_pc_o === 32'h6) begin
                found = 1'b1;
                checks++;
                if (last_fr !== 1'b0) begin
                    errors++;
                    $display("FAIL aligned_fetch_ready: got %b while emitting 4501, expected 0", last_fr);
                end
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL aligned_4501: got no 4501 at pc 6, expected one");
        end
        check_perf("aligned");
    endtask

    task automatic test_straddle;
        logic [31:0] s0 = esplit;
        mem[0] = 16'h4505; mem[1] = 16'h0513; mem[2] = 16'h0013;
        tick(1'b0, 1'b1, 1'b1, 32'h0);
        run_until(n_acc + 2, 10, "straddle");
        checks++;
        if (last_acc_instr !== 32'h0013_0513 || last_acc_pc !== 32'h2 || esplit !== s0 + 32'd1) begin
            errors++;
            $display("FAIL straddle_instr: got %h at %h, expected 00130513 at 00000002",
                     last_acc_instr, last_acc_pc);
        end
        check_perf("straddle");
    endtask

    task automatic test_backpressure;
        logic [31:0] hi, hp;
        int k = 0;
        tick(1'b0, 1'b1, 1'b1, 32'h30);
        while (!instr_valid_o && k < 10) begin
            tick(1'b1, 1'b0, 1'b0, 32'h0);
            k++;
        end
        hi = instr_o;
        hp = instr_pc_o;
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b0, 1'b0, 32'h0);
            checks++;
            if (instr_valid_o !== 1'b1 || instr_o !== hi || instr_pc_o !== hp || last_fr !== 1'b0) begin
                errors++;
                $display("FAIL backpressure_hold: got v=%b i=%h pc=%h fr=%b, expected v=1 i=%h pc=%h fr=0",
                         instr_valid_o, instr_o, instr_pc_o, last_fr, hi, hp);
            end
        end
        run_until(n_acc + 5, 20, "backpressure_resume");
        check_perf("backpressure");
    endtask

    task automatic test_flush_skip;
        int k = 0;
        mem[8'h80] = 16'hABCD;
        mem[8'h81] = 16'h4505;
        tick(1'b1, 1'b1, 1'b1, 32'h0000_0102);
        while (!instr_valid_o && k < 10) begin
            tick(1'b1, 1'b0, 1'b0, 32'h0);
            k++;
        end
        checks++;
        if (instr_valid_o !== 1'b1 || instr_o !== 32'h0000_4505 || instr_pc_o !== 32'h102 ||
            instr_compressed_o !== 1'b1) begin
            errors++;
            $display("FAIL flush_skip: got v=%b i=%h pc=%h c=%b, expected v=1 i=00004505 pc=00000102 c=1",
                     instr_valid_o, instr_o, instr_pc_o, instr_compressed_o);
        end
        run_until(n_acc + 2, 10, "flush_skip_drain");
    endtask

    task automatic test_flush_in_half;
        mem[8'h10] = 16'h4505;
        mem[8'h11] = 16'h4501;
        tick(1'b0, 1'b1, 1'b1, 32'h20);
        tick(1'b1, 1'b0, 1'b0, 32'h0);
        tick(1'b1, 1'b0, 1'b0, 32'h0);
        tick(1'b1, 1'b1, 1'b1, 32'h40);
        checks++;
        if (instr_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_half_valid: got %b, expected 0", instr_valid_o);
        end
        run_until(n_acc + 1, 10, "flush_half_first");
        checks++;
        if (last_acc_pc !== 32'h40) begin
            errors++;
            $display("FAIL flush_half_pc: got %h, expected 00000040", last_acc_pc);
        end
        check_perf("flush_half");
    endtask

    task automatic test_random;
        int start = n_acc;
        logic [31:0] fpc;
        for (int i = 0; i < 3000; i++) begin
            fpc = $urandom;
            if ($urandom_range(0, 3) == 0) fpc = 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
            tick($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 49) == 0, fpc);
        end
        run_until(n_acc + 3, 20, "random_drain");
        checks++;
        if (n_acc - start < 800) begin
            errors++;
            $display("FAIL random_progress: got %0d accepts, expected at least 800", n_acc - start);
        end
        check_perf("random");
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = 16'($urandom);
            if ($urandom_range(0, 1) == 1) mem[i][1:0] = 2'b11;
        end
        test_reset();
        test_aligned_stream();
        test_straddle();
        test_backpressure();
        test_flush_skip();
        test_flush_in_half();
        test_random();
        for (int i = 0; i < 20; i++) tick($urandom_range(0, 1) == 1, 1'b1, 1'b0, 32'h0);
        test_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
